// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU function codes, bus selects and sequencer states shared by the accumulator CPU
package cpu_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_CLAC = 4'h3;
  localparam logic [3:0] OP_INAC = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_JUMP = 4'hB;
  localparam logic [3:0] OP_JMPZ = 4'hC;
  localparam logic [3:0] OP_JPNZ = 4'hD;
  localparam logic [3:0] OP_RSV  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] ALUS_CLAC = 4'b0000;
  localparam logic [3:0] ALUS_ADD  = 4'b0001;
  localparam logic [3:0] ALUS_SUB  = 4'b0010;
  localparam logic [3:0] ALUS_INAC = 4'b0011;
  localparam logic [3:0] ALUS_AND  = 4'b0100;
  localparam logic [3:0] ALUS_OR   = 4'b0101;
  localparam logic [3:0] ALUS_NOT  = 4'b0110;
  localparam logic [3:0] ALUS_XOR  = 4'b0111;
  localparam logic [3:0] ALUS_LDAC = 4'b1000;
  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_PC   = 2'b01;
  localparam logic [1:0] BUS_DR   = 2'b10;
  localparam logic [1:0] BUS_AC   = 2'b11;
  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_F3, S_DEC, S_A1, S_A2, S_A3, S_O1, S_EX, S_W1, S_J1, S_HLT
  } state_t;
  function automatic logic [3:0] alus_of(input logic [3:0] op);
    return op == OP_LDAC ? ALUS_LDAC :
           op == OP_ADD  ? ALUS_ADD  :
           op == OP_SUB  ? ALUS_SUB  :
           op == OP_INAC ? ALUS_INAC :
           op == OP_AND  ? ALUS_AND  :
           op == OP_OR   ? ALUS_OR   :
           op == OP_NOT  ? ALUS_NOT  :
           op == OP_XOR  ? ALUS_XOR  : ALUS_CLAC;
  endfunction
endpackage

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts consecutive not-ready wait cycles and flags the one that hits TIMEOUT
module ctrl_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ready,
  output logic expired
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (TIMEOUT != 0 && en && !ready) ? cnt + CW'(1) : '0;
  assign expired = TIMEOUT != 0 && en && !ready && cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: hardwired fetch/decode/execute sequencer for the 8-bit accumulator CPU
module ctrl_unit import cpu_pkg::*; #(
  parameter int OP_W    = 4,
  parameter int ALUS_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   ir_op,
  input  logic              z,
  input  logic              mem_ready,
  output logic [ALUS_W-1:0] alus,
  output logic [1:0]        bus_sel,
  output logic              ar_ld,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              dr_ld,
  output logic              ir_ld,
  output logic              ac_ld,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              halted,
  output logic              err
);
  state_t st, nxt;
  logic [3:0] op;
  logic wait_st, expired, reg_op, taken;
  assign op = 4'(ir_op);
  assign reg_op = op inside {OP_CLAC, OP_INAC, OP_NOT};
  assign taken = op == OP_JUMP || (op == OP_JMPZ && z) || (op == OP_JPNZ && !z);
  assign wait_st = st inside {S_F2, S_A2, S_O1, S_W1};
  ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .en(wait_st), .ready(mem_ready), .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st  <= S_IDLE;
      err <= 1'b0;
    end else begin
      st <= nxt;
      if (expired) err <= 1'b1;
    end
  always_comb begin
    nxt = st;
    alus = '0;
    bus_sel = BUS_NONE;
    ar_ld = 1'b0;
    pc_ld = 1'b0;
    pc_inc = 1'b0;
    dr_ld = 1'b0;
    ir_ld = 1'b0;
    ac_ld = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    halted = st == S_HLT;
    case (st)
      S_IDLE: nxt = S_F1;
      S_F1: begin
        bus_sel = BUS_PC;
        ar_ld = 1'b1;
        nxt = S_F2;
      end
      S_F2: begin
        mem_rd = 1'b1;
        dr_ld = mem_ready;
        pc_inc = mem_ready;
        nxt = expired ? S_HLT : mem_ready ? S_F3 : S_F2;
      end
      S_F3: begin
        bus_sel = BUS_DR;
        ir_ld = 1'b1;
        nxt = S_DEC;
      end
      S_DEC: nxt = op inside {OP_NOP, OP_RSV} ? S_F1 : op == OP_HALT ? S_HLT : reg_op ? S_EX : S_A1;
      S_A1: begin
        bus_sel = BUS_PC;
        ar_ld = 1'b1;
        nxt = S_A2;
      end
      // z is only looked at in the cycle that completes the address read
      S_A2: begin
        mem_rd = 1'b1;
        dr_ld = mem_ready;
        pc_inc = mem_ready;
        nxt = expired ? S_HLT : !mem_ready ? S_A2 : taken ? S_J1 :
              op inside {OP_JMPZ, OP_JPNZ} ? S_F1 : S_A3;
      end
      S_A3: begin
        bus_sel = BUS_DR;
        ar_ld = 1'b1;
        nxt = op == OP_STAC ? S_W1 : S_O1;
      end
      S_O1: begin
        mem_rd = 1'b1;
        dr_ld = mem_ready;
        nxt = expired ? S_HLT : mem_ready ? S_EX : S_O1;
      end
      S_EX: begin
        bus_sel = reg_op ? BUS_NONE : BUS_DR;
        ac_ld = 1'b1;
        alus = ALUS_W'(alus_of(op));
        nxt = S_F1;
      end
      S_W1: begin
        bus_sel = BUS_AC;
        mem_wr = 1'b1;
        nxt = expired ? S_HLT : mem_ready ? S_F1 : S_W1;
      end
      S_J1: begin
        bus_sel = BUS_DR;
        pc_ld = 1'b1;
        nxt = S_F1;
      end
      S_HLT: nxt = S_HLT;
      default: nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: instruction-level trace model of the sequencer checked against the DUT every cycle
module tb_ctrl_unit;
  localparam int TO = 16;
  localparam logic [9:0] AR = 10'h200, PCLD = 10'h100, PCI = 10'h080, DR = 10'h040, IR = 10'h020;
  localparam logic [9:0] AC = 10'h010, RD = 10'h008, WR = 10'h004, HLT = 10'h002, ERR = 10'h001;
  localparam logic [1:0] BN = 2'b00, BP = 2'b01, BD = 2'b10, BA = 2'b11;
  logic clk = 1'b0, rst = 1'b1, z = 1'b0, mem_ready = 1'b0;
  logic [3:0] ir_op = 4'h0, alus;
  logic [1:0] bus_sel;
  logic ar_ld, pc_ld, pc_inc, dr_ld, ir_ld, ac_ld, mem_rd, mem_wr, halted, err;
  ctrl_unit #(.OP_W(4), .ALUS_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ir_op(ir_op), .z(z), .mem_ready(mem_ready),
    .alus(alus), .bus_sel(bus_sel), .ar_ld(ar_ld), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .dr_ld(dr_ld), .ir_ld(ir_ld), .ac_ld(ac_ld), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .halted(halted), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {logic rdy; logic zz; logic [3:0] op; logic [15:0] e;} rec_t;
  rec_t q[$];
  logic [15:0] seen[$];
  logic [3:0] alu_tab [16];
  logic [3:0] cur_op = 4'h0;
  logic cur_z = 1'b0, idle_rdy = 1'b1;
  int vectors = 0, errs = 0;
  wire [15:0] act = {alus, bus_sel, ar_ld, pc_ld, pc_inc, dr_ld, ir_ld, ac_ld, mem_rd, mem_wr, halted, err};
  function automatic logic [15:0] v(input logic [3:0] a, input logic [1:0] b, input logic [9:0] s);
    return {a, b, s};
  endfunction
  function automatic int cnt(input logic [9:0] m);
    int n = 0;
    foreach (seen[i]) if ((seen[i][9:0] & m) != 10'h0) n++;
    return n;
  endfunction
  task automatic check(input string nm, input logic [15:0] a, input logic [15:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
    end
  endtask
  task automatic check_int(input string nm, input int a, input int e);
    vectors++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  task automatic push(input logic [15:0] e, input logic r);
    q.push_back('{r, cur_z, cur_op, e});
  endtask
  task automatic access(input logic [9:0] req, input logic [1:0] b, input int w, input logic [9:0] done);
    for (int i = 0; i < w; i++) push(v(4'h0, b, req), 1'b0);
    push(v(4'h0, b, req | done), 1'b1);
  endtask
  // Expected per-cycle outputs of one instruction, w0/w1/w2 = wait cycles of each memory access
  task automatic instr(input logic [3:0] op, input logic zz, input int w0, input int w1, input int w2);
    cur_op = op;
    cur_z = zz;
    push(v(4'h0, BP, AR), idle_rdy);
    access(RD, BN, w0, DR | PCI);
    push(v(4'h0, BD, IR), idle_rdy);
    push(16'h0, idle_rdy);
    if (op == 4'h0 || op == 4'hE || op == 4'hF) return;
    if (op == 4'h3 || op == 4'h4 || op == 4'hA) begin
      push(v(alu_tab[op], BN, AC), idle_rdy);
      return;
    end
    push(v(4'h0, BP, AR), idle_rdy);
    access(RD, BN, w1, DR | PCI);
    if (op == 4'hB || (op == 4'hC && zz) || (op == 4'hD && !zz)) begin
      push(v(4'h0, BD, PCLD), idle_rdy);
      return;
    end
    if (op == 4'hC || op == 4'hD) return;
    push(v(4'h0, BD, AR), idle_rdy);
    if (op == 4'h2) begin
      access(WR, BA, w2, 10'h0);
      return;
    end
    access(RD, BN, w2, DR);
    push(v(alu_tab[op], BD, AC), idle_rdy);
  endtask
  task automatic play();
    seen.delete();
    while (q.size() > 0) begin
      rec_t r = q.pop_front();
      mem_ready = r.rdy;
      z = r.zz;
      ir_op = r.op;
      #1;
      seen.push_back(act);
      check("trace", act, r.e);
      @(negedge clk);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1 check("reset", act, 16'h0);
    #2 rst = 1'b0;
  endtask
  initial begin
    foreach (alu_tab[i]) alu_tab[i] = 4'h0;
    alu_tab[1] = 4'b1000; alu_tab[4] = 4'b0011; alu_tab[5] = 4'b0001; alu_tab[6] = 4'b0010;
    alu_tab[7] = 4'b0100; alu_tab[8] = 4'b0101; alu_tab[9] = 4'b0111; alu_tab[10] = 4'b0110;
    repeat (2) @(negedge clk);
    do_reset();
    push(16'h0, 1'b1);
    instr(4'h3, 1'b0, 0, 0, 0);
    play();
    check_int("clac_len", seen.size(), 6);
    check("clac_ex", seen[5], {4'b0000, 2'b00, 10'b00_0001_0000});
    instr(4'h5, 1'b0, 0, 0, 2);
    play();
    check("add_f1_after_clac", seen[0], {4'b0000, 2'b01, 10'b10_0000_0000});
    check_int("add_mem_rd_cycles", cnt(RD), 5);
    check_int("add_dr_ld_count", cnt(DR), 3);
    check("add_ex", seen[10], {4'b0001, 2'b10, 10'b00_0001_0000});
    instr(4'h2, 1'b0, 0, 0, 0);
    play();
    check_int("stac_len", seen.size(), 8);
    check_int("stac_ac_ld", cnt(AC), 0);
    check("stac_w1", seen[7], {4'b0000, 2'b11, 10'b00_0000_0100});
    instr(4'hC, 1'b1, 0, 0, 0);
    play();
    check_int("jmpz_taken_len", seen.size(), 7);
    check("jmpz_j1", seen[6], {4'b0000, 2'b10, 10'b01_0000_0000});
    instr(4'hC, 1'b0, 0, 0, 0);
    play();
    check_int("jmpz_untaken_len", seen.size(), 6);
    check_int("jmpz_untaken_pc_inc", cnt(PCI), 2);
    check_int("jmpz_untaken_pc_ld", cnt(PCLD), 0);
    idle_rdy = 1'b0;
    instr(4'h1, 1'b0, 1, 3, 15);
    instr(4'h6, 1'b1, 0, 2, 1);
    instr(4'h7, 1'b0, 2, 0, 0);
    instr(4'h8, 1'b0, 0, 0, 4);
    instr(4'h9, 1'b1, 0, 1, 0);
    instr(4'h4, 1'b0, 3, 0, 0);
    instr(4'hA, 1'b0, 0, 0, 0);
    idle_rdy = 1'b1;
    instr(4'h0, 1'b0, 0, 0, 0);
    instr(4'hE, 1'b0, 1, 0, 0);
    instr(4'hB, 1'b1, 0, 2, 0);
    instr(4'hD, 1'b0, 0, 0, 0);
    instr(4'hD, 1'b1, 0, 1, 0);
    instr(4'h2, 1'b0, 1, 0, 3);
    play();
    do_reset();
    cur_op = 4'h0;
    push(16'h0, 1'b0);
    push(v(4'h0, BP, AR), 1'b0);
    for (int i = 0; i < TO; i++) push(v(4'h0, BN, RD), 1'b0);
    for (int i = 0; i < 4; i++) push(v(4'h0, BN, HLT | ERR), 1'b0);
    play();
    check("timeout_last_wait", seen[17], {4'b0000, 2'b00, 10'b00_0000_1000});
    check("timeout_hlt", seen[18], {4'b0000, 2'b00, 10'b00_0000_0011});
    do_reset();
    push(16'h0, 1'b1);
    instr(4'hF, 1'b0, 0, 0, 0);
    for (int i = 0; i < 20; i++) push(v(4'h0, BN, HLT), 1'b1);
    play();
    check("halt_first", seen[5], {4'b0000, 2'b00, 10'b00_0000_0010});
    check_int("halt_cycles", cnt(HLT), 20);
    do_reset();
    push(16'h0, 1'b1);
    instr(4'h1, 1'b0, 0, 5, 0);
    while (q.size() > 8) void'(q.pop_back());
    play();
    check("mid_a2_rd", seen[7], {4'b0000, 2'b00, 10'b00_0000_1000});
    do_reset();
    push(16'h0, 1'b1);
    instr(4'h3, 1'b0, 0, 0, 0);
    play();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
